// File: rtl/conf_split_2_df.sv
// Two-way dataflow split: captures a payload into the selected branch register, pulses that
// branch's drive after a fixed latency, then returns the branch's free upstream.
module conf_split_2_df #(
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned OUT_DELAY  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_drive,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_sel,
   output logic                  o_free,
   output logic                  o_drive0,
   output logic                  o_drive1,
   output logic [DATA_WIDTH-1:0] o_data0,
   output logic [DATA_WIDTH-1:0] o_data1,
   input  logic                  i_freeNext0,
   input  logic                  i_freeNext1,
   output logic                  o_busy,
   output logic                  o_err
);

   typedef enum logic [1:0] {StIdle, StHold, StDrive, StWait} state_e;

   // HOLD covers OUT_DELAY-1 cycles; a delay of one goes straight to DRIVE.
   localparam logic [7:0] CntLoad  = 8'(OUT_DELAY - 1);
   localparam bit         SkipHold = (OUT_DELAY <= 32'd1);

   state_e                state_q, state_d;
   logic                  sel_q, sel_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  pend_q, pend_d;
   logic [DATA_WIDTH-1:0] data0_q, data0_d;
   logic [DATA_WIDTH-1:0] data1_q, data1_d;
   logic                  err_q, err_d;
   logic                  free_q, free_d;
   logic                  drive0_q, drive0_d;
   logic                  drive1_q, drive1_d;
   logic                  busy_q, busy_d;
   logic                  done;
   logic                  free_sel;
   logic                  free_oth;

   assign free_sel = sel_q ? i_freeNext1 : i_freeNext0;
   assign free_oth = sel_q ? i_freeNext0 : i_freeNext1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         sel_q    <= 1'b0;
         cnt_q    <= 8'd0;
         pend_q   <= 1'b0;
         data0_q  <= '0;
         data1_q  <= '0;
         err_q    <= 1'b0;
         free_q   <= 1'b0;
         drive0_q <= 1'b0;
         drive1_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
         data0_q  <= data0_d;
         data1_q  <= data1_d;
         err_q    <= err_d;
         free_q   <= free_d;
         drive0_q <= drive0_d;
         drive1_q <= drive1_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      data0_d = data0_q;
      data1_d = data1_q;
      err_d   = err_q;
      done    = 1'b0;
      case (state_q)
         StIdle: begin
            if (i_drive) begin
               sel_d   = i_sel;
               cnt_d   = CntLoad;
               pend_d  = 1'b0;
               state_d = SkipHold ? StDrive : StHold;
               if (i_sel) data1_d = i_data;
               else       data0_d = i_data;
            end
            if (i_freeNext0 || i_freeNext1) err_d = 1'b1;
         end
         StHold: begin
            // An early free is remembered so the drive pulse still goes out first.
            if (free_sel) pend_d = 1'b1;
            if (cnt_q <= 8'd1) state_d = StDrive;
            else               cnt_d   = cnt_q - 8'd1;
         end
         StDrive: begin
            if (free_sel || pend_q) begin
               state_d = StIdle;
               pend_d  = 1'b0;
               done    = 1'b1;
            end else begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (free_sel) begin
               state_d = StIdle;
               done    = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
      if (state_q != StIdle && (i_drive || free_oth)) err_d = 1'b1;
   end

   always_comb begin
      free_d   = done;
      drive0_d = (state_d == StDrive) && !sel_d;
      drive1_d = (state_d == StDrive) && sel_d;
      busy_d   = (state_d != StIdle);
   end

   assign o_free   = free_q;
   assign o_drive0 = drive0_q;
   assign o_drive1 = drive1_q;
   assign o_data0  = data0_q;
   assign o_data1  = data1_q;
   assign o_busy   = busy_q;
   assign o_err    = err_q;

endmodule

// File: tb/tb_conf_split_2_df.sv
// Bench for conf_split_2_df: two instances (delay 4 and delay 1) share stimulus and are checked
// every cycle against a timestamp-based transaction model, plus a directed table and sequences.
module tb_conf_split_2_df;

   localparam int DW = 16;
   localparam int DA = 4;
   localparam int DB = 1;
   localparam bit H  = 1'b1;
   localparam bit L  = 1'b0;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_drive = 1'b0;
   logic          i_sel = 1'b0;
   logic          f0 = 1'b0;
   logic          f1 = 1'b0;
   logic [DW-1:0] i_data = '0;

   logic          w_free   [2];
   logic          w_drive0 [2];
   logic          w_drive1 [2];
   logic          w_busy   [2];
   logic          w_err    [2];
   logic [DW-1:0] w_d0     [2];
   logic [DW-1:0] w_d1     [2];

   conf_split_2_df #(.DATA_WIDTH(DW), .OUT_DELAY(DA)) u_dut_a (
      .clk(clk), .rst(rst), .i_drive(i_drive), .i_data(i_data), .i_sel(i_sel),
      .o_free(w_free[0]), .o_drive0(w_drive0[0]), .o_drive1(w_drive1[0]),
      .o_data0(w_d0[0]), .o_data1(w_d1[0]), .i_freeNext0(f0), .i_freeNext1(f1),
      .o_busy(w_busy[0]), .o_err(w_err[0])
   );

   conf_split_2_df #(.DATA_WIDTH(DW), .OUT_DELAY(DB)) u_dut_b (
      .clk(clk), .rst(rst), .i_drive(i_drive), .i_data(i_data), .i_sel(i_sel),
      .o_free(w_free[1]), .o_drive0(w_drive0[1]), .o_drive1(w_drive1[1]),
      .o_data0(w_d0[1]), .o_data1(w_d1[1]), .i_freeNext0(f0), .i_freeNext1(f1),
      .o_busy(w_busy[1]), .o_err(w_err[1])
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Model: a transaction is its capture cycle plus the cycle its free pulse is due (-1 = none).
   int            m_dly     [2] = '{DA, DB};
   bit            m_txn     [2];
   bit            m_sel     [2];
   int            m_tacc    [2];
   int            m_free_at [2];
   logic [DW-1:0] m_d0      [2];
   logic [DW-1:0] m_d1      [2];
   bit            m_err     [2];

   typedef struct {
      bit drv; bit sel; logic [DW-1:0] data; bit fa; bit fb;
      bit e_drv0; bit e_drv1; bit e_free; bit e_busy; logic [DW-1:0] e_d0; logic [DW-1:0] e_d1;
   } vec_t;

   vec_t tbl [$];

   function automatic vec_t mk(bit drv, bit sel, logic [DW-1:0] data, bit fa, bit fb,
                               bit ed0, bit ed1, bit efr, bit ebz,
                               logic [DW-1:0] dd0, logic [DW-1:0] dd1);
      vec_t v;
      v.drv = drv; v.sel = sel; v.data = data; v.fa = fa; v.fb = fb;
      v.e_drv0 = ed0; v.e_drv1 = ed1; v.e_free = efr; v.e_busy = ebz; v.e_d0 = dd0; v.e_d1 = dd1;
      return v;
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
      end
   endtask

   task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic bit m_busy(int k, int n);
      return m_txn[k] && (n > m_tacc[k]) && !(m_free_at[k] >= 0 && n >= m_free_at[k]);
   endfunction

   task automatic model_reset(int k);
      m_txn[k] = 1'b0; m_sel[k] = 1'b0; m_tacc[k] = 0; m_free_at[k] = -1;
      m_d0[k] = '0; m_d1[k] = '0; m_err[k] = 1'b0;
   endtask

   task automatic model_check(int k);
      bit drv;
      drv = m_txn[k] && (cyc == m_tacc[k] + m_dly[k]);
      chk1($sformatf("busy%0d", k),   w_busy[k],   m_busy(k, cyc));
      chk1($sformatf("drive0_%0d", k), w_drive0[k], drv && !m_sel[k]);
      chk1($sformatf("drive1_%0d", k), w_drive1[k], drv && m_sel[k]);
      chk1($sformatf("free%0d", k),   w_free[k],   m_free_at[k] == cyc);
      chk1($sformatf("err%0d", k),    w_err[k],    m_err[k]);
      chkd($sformatf("data0_%0d", k), w_d0[k],     m_d0[k]);
      chkd($sformatf("data1_%0d", k), w_d1[k],     m_d1[k]);
   endtask

   task automatic model_update(int k);
      bit fs, fo;
      fs = m_sel[k] ? f1 : f0;
      fo = m_sel[k] ? f0 : f1;
      if (!m_busy(k, cyc)) begin
         if (f0 || f1) m_err[k] = 1'b1;
         if (i_drive) begin
            m_txn[k] = 1'b1; m_sel[k] = i_sel; m_tacc[k] = cyc; m_free_at[k] = -1;
            if (i_sel) m_d1[k] = i_data;
            else       m_d0[k] = i_data;
         end
      end else begin
         if (i_drive || fo) m_err[k] = 1'b1;
         if (fs && m_free_at[k] < 0)
            m_free_at[k] = (cyc < m_tacc[k] + m_dly[k]) ? m_tacc[k] + m_dly[k] + 1 : cyc + 1;
      end
   endtask

   // Called at a falling edge: check this cycle, apply inputs, advance one cycle.
   task automatic step(input bit drv, input bit sel, input logic [DW-1:0] data,
                       input bit fa, input bit fb);
      for (int k = 0; k < 2; k++) model_check(k);
      i_drive = drv; i_sel = sel; i_data = data; f0 = fa; f1 = fb;
      for (int k = 0; k < 2; k++) model_update(k);
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle();
      step(L, L, '0, L, L);
   endtask

   task automatic chk_zero();
      for (int k = 0; k < 2; k++) begin
         chk1($sformatf("rst_free%0d", k),   w_free[k],   L);
         chk1($sformatf("rst_drive0_%0d", k), w_drive0[k], L);
         chk1($sformatf("rst_drive1_%0d", k), w_drive1[k], L);
         chk1($sformatf("rst_busy%0d", k),   w_busy[k],   L);
         chk1($sformatf("rst_err%0d", k),    w_err[k],    L);
         chkd($sformatf("rst_data0_%0d", k), w_d0[k],     '0);
         chkd($sformatf("rst_data1_%0d", k), w_d1[k],     '0);
      end
   endtask

   // Asserts reset between clock edges so only the asynchronous path can clear the outputs.
   task automatic do_reset();
      i_drive = L; i_sel = L; i_data = '0; f0 = L; f1 = L;
      #2 rst = 1'b0;
      #1;
      chk_zero();
      for (int k = 0; k < 2; k++) model_reset(k);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      logic [DW-1:0] A5, C3, rd;
      bit            drv, sel, fs, fw;
      A5 = 16'h00A5;
      C3 = 16'h003C;
      //                 drv sel data fa fb | drv0 drv1 free busy d0   d1
      tbl.push_back(mk(H, L, A5, L, L,  L, L, L, L, '0, '0));
      tbl.push_back(mk(L, L, '0, L, L,  L, L, L, H, A5, '0));
      tbl.push_back(mk(L, L, '0, L, L,  L, L, L, H, A5, '0));
      tbl.push_back(mk(L, L, '0, L, L,  L, L, L, H, A5, '0));
      tbl.push_back(mk(L, L, '0, L, L,  H, L, L, H, A5, '0));
      for (int i = 0; i < 5; i++) tbl.push_back(mk(L, L, '0, L, L,  L, L, L, H, A5, '0));
      tbl.push_back(mk(L, L, '0, H, L,  L, L, L, H, A5, '0));
      tbl.push_back(mk(H, H, C3, L, L,  L, L, H, L, A5, '0));
      tbl.push_back(mk(L, L, '0, L, L,  L, L, L, H, A5, C3));
      tbl.push_back(mk(L, L, '0, L, L,  L, L, L, H, A5, C3));
      tbl.push_back(mk(L, L, '0, L, L,  L, L, L, H, A5, C3));
      tbl.push_back(mk(L, L, '0, L, L,  L, H, L, H, A5, C3));
      tbl.push_back(mk(L, L, '0, L, H,  L, L, L, H, A5, C3));
      tbl.push_back(mk(L, L, '0, L, L,  L, L, H, L, A5, C3));

      for (int k = 0; k < 2; k++) model_reset(k);
      repeat (2) @(negedge clk);
      chk_zero();
      rst = 1'b1;
      repeat (10) idle();

      foreach (tbl[i]) begin
         chk1("tbl_drive0", w_drive0[0], tbl[i].e_drv0);
         chk1("tbl_drive1", w_drive1[0], tbl[i].e_drv1);
         chk1("tbl_free",   w_free[0],   tbl[i].e_free);
         chk1("tbl_busy",   w_busy[0],   tbl[i].e_busy);
         chk1("tbl_err",    w_err[0],    L);
         chkd("tbl_data0",  w_d0[0],     tbl[i].e_d0);
         chkd("tbl_data1",  w_d1[0],     tbl[i].e_d1);
         step(tbl[i].drv, tbl[i].sel, tbl[i].data, tbl[i].fa, tbl[i].fb);
      end

      // Drive while waiting and a wrong-branch free: flagged, nothing else changes.
      step(H, L, 16'h0011, L, L);
      repeat (5) idle();
      chk1("wait_busy", w_busy[0], H);
      step(H, H, 16'h0077, L, L);
      chk1("viol_err",   w_err[0], H);
      chkd("viol_data1", w_d1[0],  16'h003C);
      chkd("viol_data0", w_d0[0],  16'h0011);
      chk1("viol_busy",  w_busy[0], H);
      step(L, L, '0, L, H);
      chk1("wrong_free_busy", w_busy[0], H);
      step(L, L, '0, H, L);
      chk1("viol_free", w_free[0], H);
      chk1("viol_idle", w_busy[0], L);
      idle();
      chk1("err_sticky", w_err[0], H);
      do_reset();

      // Free arriving during HOLD: drive pulse first, free the following cycle.
      step(H, H, 16'h005A, L, L);
      idle();
      step(L, L, '0, L, H);
      idle();
      chk1("early_drive1", w_drive1[0], H);
      chk1("early_nofree", w_free[0],   L);
      idle();
      chk1("early_free",   w_free[0],   H);
      chk1("early_idle",   w_busy[0],   L);

      // Reset during HOLD aborts; next transaction runs with normal latency.
      step(H, L, 16'h0099, L, L);
      idle();
      chk1("hold_busy", w_busy[0], H);
      do_reset();
      repeat (6) idle();
      step(H, L, 16'h00BB, L, L);
      chk1("d1_drive_next", w_drive0[1], H);
      chk1("d4_no_drive",   w_drive0[0], L);
      chkd("post_rst_data", w_d0[0],     16'h00BB);
      repeat (3) idle();
      chk1("post_rst_drive", w_drive0[0], H);
      step(L, L, '0, H, L);
      chk1("post_rst_free_a", w_free[0], H);
      chk1("post_rst_free_b", w_free[1], H);

      for (int n = 0; n < 3000; n++) begin
         if (n % 250 == 249) do_reset();
         drv = ($urandom_range(0, 3) == 0);
         sel = 1'($urandom_range(0, 1));
         rd  = DW'($urandom);
         fs  = ($urandom_range(0, 4) == 0);
         fw  = ($urandom_range(0, 39) == 0);
         step(drv, sel, rd, m_sel[0] ? fw : fs, m_sel[0] ? fs : fw);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
